cdc_sync_bank: RTL
==================

# cdc_sync_bank

Parametrised multi-channel clock-domain-crossing receiver, successor to the fixed 8-bit two-stage synchroniser. It brings CHANNELS asynchronous WIDTH-bit buses into the local clock domain through a configurable-depth flop chain. Each bus has a stability filter, so it commits only after the synchronised value has held steady. Each channel also gets a toggle-to-pulse event path with pending/overrun tracking, so control events from a faster or slower domain are neither lost silently nor duplicated.

## Interface
- CHANNELS, 4, number of independent channels (≥1)
- WIDTH, 8, bits per data bus (≥1)
- STAGES, 2, synchroniser flop depth (≥2)
- STABLE, 2, consecutive equal synchronised samples required before commit (≥1); counter width is clog2(STABLE+1)
- RESET_VAL, 0, WIDTH-bit reset value of every data chain, candidate and output
- clk  in  1  destination-domain clock; the block's only clock
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
- async_in  in  CHANNELS*WIDTH  source buses; channel c = bits [c*WIDTH +: WIDTH]
- toggle_in  in  CHANNELS  source event toggles; one event per transition
- evt_ack  in  CHANNELS  clears evt_pending[c]
- ovr_clr  in  CHANNELS  clears overrun[c]
- sync_out  out  CHANNELS*WIDTH  committed, filtered data per channel
- out_valid  out  CHANNELS  1-cycle strobe when sync_out[c] changes
- pulse_out  out  CHANNELS  1-cycle strobe per toggle_in[c] transition
- evt_pending  out  CHANNELS  sticky event flag
- overrun  out  CHANNELS  sticky: event arrived while previous one still pending

## Operation
- Data chain: per channel, STAGES registers. stage0 <= async_in. stage[k] <= stage[k-1]. s = stage[STAGES-1]. No logic between stages.
- Stability filter (per channel registers cand, cnt):
  - s != cand: cand <= s, cnt <= 0.
  - s == cand and cnt < STABLE-1: cnt <= cnt+1.
  - s == cand and cnt == STABLE-1:
    - If cand != sync_out: sync_out <= cand, out_valid <= 1.
    - cnt <= STABLE (saturate; no further commits until cand reloads).
  - All other cycles: out_valid <= 0.
- Glitch rejection: a change lasting fewer than STABLE synchronised cycles reloads cand and never reaches sync_out.
- A change back to the current sync_out value resets the filter and produces no out_valid.
- Event chain: per channel, STAGES toggle flops, then t_d <= t_s, and pulse_out <= t_s ^ t_d (registered).
- evt_pending[c], priority high to low:
  - pulse (internal t_s^t_d) → set.
  - evt_ack → clear.
  - otherwise hold.
  - pulse and evt_ack in the same cycle → stays 1; the new event wins.
- overrun[c]:
  - Set when pulse occurs while evt_pending=1 and evt_ack=0.
  - Cleared only by ovr_clr (set wins if both occur) or by reset.
- Channels are fully independent; no cross-channel coherence is guaranteed. Multi-bit coherence within a channel is the filter's job: the source must hold a bus ≥ STAGES+STABLE+1 destination cycles.

## Timing
- Reset (rst=0 at posedge):
  - data stages, cand, sync_out ← RESET_VAL.
  - cnt ← 0.
  - toggle stages, t_d, pulse_out, out_valid, evt_pending, overrun ← 0.
  - evt_ack and ovr_clr are ignored during reset.
- Reset asserted mid-operation takes effect on the next edge. In-flight data and events are discarded with no strobes.
- Data latency: async_in changes before edge 1, stays stable, and differs from sync_out. sync_out updates and out_valid is high after edge STAGES+1+STABLE (default 5). out_valid is exactly 1 cycle wide.
- Event latency: toggle_in flips before edge 1. pulse_out is high for the single cycle after edge STAGES+1 (default 3). evt_pending rises at the same edge.
- Minimum toggle spacing for distinct pulses: 2 destination cycles. Closer toggles may cancel in the chain, and this is documented source-side behaviour.
- If toggle_in=1 at reset release, exactly one pulse is produced at edge STAGES+1 after release.

## Test plan
- Reset then defaults: CHANNELS=4, WIDTH=8, RESET_VAL=0x00 → all outputs 0; drive ch0 0x5A at cycle 10 → sync_out[7:0]=0x5A with out_valid[0]=1 after edge 15, single cycle; other channels quiet.
- Glitch: ch1 0x00→0xFF for 1 cycle then back → no out_valid[1], sync_out unchanged; 0xFF held 4 cycles → commit at STAGES+1+STABLE.
- Events: toggle ch2 at cycles 5 and 20, no ack → pulse_out[2] at 8 and 23; evt_pending=1 from 8; overrun[2]=1 from 23; ovr_clr → 0.
- Ack collision: pulse and evt_ack same cycle → evt_pending stays 1, overrun unchanged; ack alone next cycle → 0.
- Reset mid-flight: change ch3 to 0x33, assert rst at edge STAGES+1 → sync_out stays RESET_VAL, no out_valid; toggle_in held 1 through reset → one pulse_out at release+3.
- Parameter sweep: STAGES=3, STABLE=1, WIDTH=1, CHANNELS=1 → data latency 5, event latency 4.

Source files
------------

// File: rtl/cdc_sync_bank_if.sv
// cdc_sync_bank_if: CDC bank bus; source side async_in/toggle_in/evt_ack/ovr_clr, destination side sync_out/out_valid/pulse_out/evt_pending/overrun
interface cdc_sync_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 8
);
  logic [CHANNELS*WIDTH-1:0] async_in;
  logic [CHANNELS*WIDTH-1:0] sync_out;
  logic [CHANNELS-1:0] toggle_in;
  logic [CHANNELS-1:0] evt_ack;
  logic [CHANNELS-1:0] ovr_clr;
  logic [CHANNELS-1:0] out_valid;
  logic [CHANNELS-1:0] pulse_out;
  logic [CHANNELS-1:0] evt_pending;
  logic [CHANNELS-1:0] overrun;
  modport master (
    output async_in, toggle_in, evt_ack, ovr_clr,
    input sync_out, out_valid, pulse_out, evt_pending, overrun
  );
  modport slave (
    input async_in, toggle_in, evt_ack, ovr_clr,
    output sync_out, out_valid, pulse_out, evt_pending, overrun
  );
endinterface

// File: rtl/cdc_sync_bank.sv
// cdc_sync_bank: per-channel filtered bus synchroniser and toggle-to-pulse event path; clk, rst (sync active-low), bus (slave: async_in/toggle_in/evt_ack/ovr_clr in, sync_out/out_valid/pulse_out/evt_pending/overrun out)
module cdc_sync_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 8,
  parameter int STAGES = 2,
  parameter int STABLE = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic rst,
  cdc_sync_bank_if.slave bus
);
  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE - 1);
  localparam logic [CW-1:0] SAT = CW'(STABLE);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] data_q [STAGES];
    logic [WIDTH-1:0] data_d [STAGES];
    logic [WIDTH-1:0] cand_q, cand_d, out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [STAGES-1:0] tog_q, tog_d;
    logic valid_q, valid_d, td_q, td_d, pulse_q, pulse_d, pend_q, pend_d, ovr_q, ovr_d;
    logic same, commit, pulse, ack;
    always_comb begin
      data_d[0] = bus.async_in[c*WIDTH +: WIDTH];
      for (int k = 1; k < STAGES; k++) data_d[k] = data_q[k-1];
      tog_d = {tog_q[STAGES-2:0], bus.toggle_in[c]};
      same = data_q[STAGES-1] == cand_q;
      commit = same && cnt_q == LAST && cand_q != out_q;
      cand_d = data_q[STAGES-1];
      cnt_d = !same ? '0 : cnt_q == LAST ? SAT : cnt_q == SAT ? cnt_q : cnt_q + CW'(1);
      out_d = commit ? cand_q : out_q;
      valid_d = commit;
      pulse = tog_q[STAGES-1] ^ td_q;
      td_d = tog_q[STAGES-1];
      pulse_d = pulse;
      ack = bus.evt_ack[c];
      pend_d = pulse || (pend_q && !ack);
      ovr_d = (pulse && pend_q && !ack) || (ovr_q && !bus.ovr_clr[c]);
    end
    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int k = 0; k < STAGES; k++) data_q[k] <= RESET_VAL;
        cand_q <= RESET_VAL;
        out_q <= RESET_VAL;
        cnt_q <= '0;
        tog_q <= '0;
        {valid_q, td_q, pulse_q, pend_q, ovr_q} <= '0;
      end else begin
        data_q <= data_d;
        cand_q <= cand_d;
        out_q <= out_d;
        cnt_q <= cnt_d;
        tog_q <= tog_d;
        {valid_q, td_q, pulse_q, pend_q, ovr_q} <= {valid_d, td_d, pulse_d, pend_d, ovr_d};
      end
    end
    assign bus.sync_out[c*WIDTH +: WIDTH] = out_q;
    assign bus.out_valid[c] = valid_q;
    assign bus.pulse_out[c] = pulse_q;
    assign bus.evt_pending[c] = pend_q;
    assign bus.overrun[c] = ovr_q;
  end
endmodule
